// File: rtl/color_sensor_decoder.sv
// color_sensor_decoder
//   Drives a TCS3200-style colour sensor. The filter selects step through
//   red, green and blue. Sensor pulses are counted in a fixed window for each
//   filter. The dominant colour is published as a 2-bit code
//   (0 none, 1 red, 2 green, 3 blue) once it has been stable.
//
// Ports
//   clk_1MHz     in   system clock
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = measure continuously, 0 = idle
//   sensor_out   in   sensor frequency output (asynchronous)
//   s0, s1       out  frequency scaling select, fixed at 20 %
//   s2, s3       out  photodiode filter select
//   color        out  decided colour code
//   color_valid  out  one-cycle pulse when color changes value
//
// FSM states
//   state    | meaning
//   IDLE     | waiting for enable, red filter selected
//   R_SETTLE | red filter selected, sensor output settling
//   R_COUNT  | counting red pulses
//   G_SETTLE | green filter selected, sensor output settling
//   G_COUNT  | counting green pulses
//   B_SETTLE | blue filter selected, sensor output settling
//   B_COUNT  | counting blue pulses
//   DECIDE   | pick candidate colour, update stability and output

module color_sensor_decoder #(
  parameter int SETTLE_CYCLES = 100,
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 12,
  parameter int MIN_COUNT     = 20,
  parameter int STABLE_N      = 2
) (
  input  logic       clk_1MHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       sensor_out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [1:0] color,
  output logic       color_valid
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SW      = $clog2(STABLE_N + 1);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0]    STAB_MAX  = SW'(STABLE_N);

  typedef enum logic [2:0] {
    IDLE,
    R_SETTLE,
    R_COUNT,
    G_SETTLE,
    G_COUNT,
    B_SETTLE,
    B_COUNT,
    DECIDE
  } state_t;

  state_t state, state_next;

  logic [TMR_W-1:0] timer, timer_next;
  logic             timer_tc;

  logic [2:0]       cnt_clr;
  logic [2:0]       cnt_en;
  logic             decide_en;

  logic             sync1, sync2, sync_prev;
  logic             pulse;

  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] max_rg, cnt_max;
  logic [1:0]       cand;

  logic [1:0]       prev_cand;
  logic [SW-1:0]    stab_cnt;
  logic [SW-1:0]    stab_inc, stab_new;

  logic [1:0]       filt_next;

  assign s0 = 1'b1;
  assign s1 = 1'b0;

  // Two-flop synchroniser followed by a rising-edge detect.
  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= sensor_out;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign pulse = sync2 & ~sync_prev;

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  assign timer_tc = (timer == '0);

  always_comb begin
    state_next = state;
    timer_next = timer;
    cnt_clr    = 3'b000;
    cnt_en     = 3'b000;
    decide_en  = 1'b0;
    if (!timer_tc)
      timer_next = timer - TMR_W'(1);

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = R_SETTLE;
          timer_next = SETTLE_LD;
        end
      end
      R_SETTLE: begin
        if (timer_tc) begin
          state_next = R_COUNT;
          timer_next = WINDOW_LD;
          cnt_clr[0] = 1'b1;
        end
      end
      R_COUNT: begin
        cnt_en[0] = 1'b1;
        if (timer_tc) begin
          state_next = G_SETTLE;
          timer_next = SETTLE_LD;
        end
      end
      G_SETTLE: begin
        if (timer_tc) begin
          state_next = G_COUNT;
          timer_next = WINDOW_LD;
          cnt_clr[1] = 1'b1;
        end
      end
      G_COUNT: begin
        cnt_en[1] = 1'b1;
        if (timer_tc) begin
          state_next = B_SETTLE;
          timer_next = SETTLE_LD;
        end
      end
      B_SETTLE: begin
        if (timer_tc) begin
          state_next = B_COUNT;
          timer_next = WINDOW_LD;
          cnt_clr[2] = 1'b1;
        end
      end
      B_COUNT: begin
        cnt_en[2] = 1'b1;
        if (timer_tc) begin
          state_next = DECIDE;
          timer_next = '0;
        end
      end
      DECIDE: begin
        decide_en  = 1'b1;
        state_next = R_SETTLE;
        timer_next = SETTLE_LD;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Dropping enable abandons the measurement. A DECIDE cycle with
    // enable low makes no decision.
    if (!enable) begin
      state_next = IDLE;
      timer_next = '0;
      decide_en  = 1'b0;
    end
  end

  // The filter select is registered from the next state. This keeps the
  // pins glitch-free and aligned with the state register.
  always_comb begin
    filt_next = 2'b00;
    case (state_next)
      G_SETTLE, G_COUNT: filt_next = 2'b11;
      B_SETTLE, B_COUNT: filt_next = 2'b01;
      default:           filt_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s2 <= filt_next[1];
      s3 <= filt_next[0];
    end
  end

  // Per-channel saturating pulse counters. Each counter is cleared on the
  // last settle cycle, so the first count cycle starts from zero.
  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr[i])
          cnt[i] <= '0;
        else if (cnt_en[i] && pulse && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // The candidate favours red, then green, then blue when counts tie.
  always_comb begin
    max_rg  = (cnt[0] >= cnt[1]) ? cnt[0] : cnt[1];
    cnt_max = (max_rg >= cnt[2]) ? max_rg : cnt[2];
    cand    = 2'd0;
    if (int'(cnt_max) < MIN_COUNT)
      cand = 2'd0;
    else if (cnt[0] == cnt_max)
      cand = 2'd1;
    else if (cnt[1] == cnt_max)
      cand = 2'd2;
    else
      cand = 2'd3;
  end

  always_comb begin
    stab_inc = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + SW'(1);
    stab_new = (cand == prev_cand) ? stab_inc : SW'(1);
  end

  always_ff @(posedge clk_1MHz or posedge reset) begin
    if (reset) begin
      prev_cand   <= 2'd0;
      stab_cnt    <= '0;
      color       <= 2'd0;
      color_valid <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      if (!enable) begin
        stab_cnt <= '0;
      end else if (decide_en) begin
        prev_cand <= cand;
        stab_cnt  <= stab_new;
        if ((stab_new == STAB_MAX) && (cand != color)) begin
          color       <= cand;
          color_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_sensor_decoder.sv
module tb_color_sensor_decoder;

  localparam int S    = 4;
  localparam int W    = 100;
  localparam int MINC = 10;
  localparam int SN   = 2;
  localparam int SW   = S + W;
  localparam int P    = 3 * SW + 1;

  logic clk_1MHz = 1'b0;
  logic reset;
  logic enable;
  logic sensor_out;

  logic       s0_a, s1_a, s2_a, s3_a, valid_a;
  logic [1:0] color_a;
  logic       s0_b, s1_b, s2_b, s3_b, valid_b;
  logic [1:0] color_b;

  always #5 clk_1MHz = ~clk_1MHz;

  color_sensor_decoder #(
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(12), .MIN_COUNT(MINC), .STABLE_N(SN)
  ) dut_a (
    .clk_1MHz(clk_1MHz), .reset(reset), .enable(enable), .sensor_out(sensor_out),
    .s0(s0_a), .s1(s1_a), .s2(s2_a), .s3(s3_a), .color(color_a), .color_valid(valid_a)
  );

  color_sensor_decoder #(
    .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4), .MIN_COUNT(MINC), .STABLE_N(SN)
  ) dut_b (
    .clk_1MHz(clk_1MHz), .reset(reset), .enable(enable), .sensor_out(sensor_out),
    .s0(s0_b), .s1(s1_b), .s2(s2_b), .s3(s3_b), .color(color_b), .color_valid(valid_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
  endtask

  // Reference model: timeline of one measurement cycle measured in clock
  // edges from the edge that left IDLE. Index 0 is the CNT_W=12 unit, 1 the
  // CNT_W=4 unit.
  int sat [2] = '{4095, 15};
  int m_cnt [2][3];
  int m_stab [2];
  int m_prev [2];
  int m_color [2];
  int m_valid [2];
  bit h0, h1, h2, h3;
  bit run;
  int e = 0;
  int e0 = 0;
  int cur_off = -1;
  int nd = 0;
  int mo, mch, mip, mx, cand, nw;

  task automatic model_reset();
    run = 0;
    cur_off = -1;
    {h3, h2, h1, h0} = 4'b0000;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) m_cnt[d][c] = 0;
      m_stab[d] = 0;
      m_prev[d] = 0;
      m_color[d] = 0;
      m_valid[d] = 0;
    end
  endtask

  task automatic model_decide();
    for (int d = 0; d < 2; d++) begin
      mx = m_cnt[d][0];
      if (m_cnt[d][1] > mx) mx = m_cnt[d][1];
      if (m_cnt[d][2] > mx) mx = m_cnt[d][2];
      cand = 0;
      if (mx >= MINC) begin
        for (int c = 2; c >= 0; c--)
          if (m_cnt[d][c] == mx) cand = c + 1;
      end
      if (cand == m_prev[d])
        nw = (m_stab[d] + 1 > SN) ? SN : m_stab[d] + 1;
      else
        nw = 1;
      m_prev[d] = cand;
      m_stab[d] = nw;
      if (nw >= SN && cand != m_color[d]) begin
        m_color[d] = cand;
        m_valid[d] = 1;
      end
    end
  endtask

  function automatic int exp_filter(input int o);
    if (o < 0) return 0;
    if (o / SW == 1) return 3;
    if (o / SW == 2) return 1;
    return 0;
  endfunction

  always @(posedge clk_1MHz) begin
    e++;
    if (reset) begin
      model_reset();
    end else begin
      {h3, h2, h1, h0} = {h2, h1, h0, sensor_out};
      m_valid[0] = 0;
      m_valid[1] = 0;
      if (!enable) begin
        run = 0;
        cur_off = -1;
        m_stab[0] = 0;
        m_stab[1] = 0;
      end else if (!run) begin
        run = 1;
        e0 = e;
        cur_off = 0;
      end else begin
        mo  = (e - e0 - 1) % P;
        mch = mo / SW;
        mip = mo % SW;
        if (mch < 3 && mip >= S) begin
          for (int d = 0; d < 2; d++) begin
            if (mip == S) m_cnt[d][mch] = 0;
            // A pin rise sampled two edges earlier is counted on this edge.
            if (h2 && !h3 && m_cnt[d][mch] < sat[d]) m_cnt[d][mch]++;
          end
        end else if (mch == 3) begin
          model_decide();
          nd++;
        end
        cur_off = (e - e0) % P;
      end
    end
  end

  always @(negedge clk_1MHz) begin
    chk("a.color", color_a, m_color[0]);
    chk("a.color_valid", valid_a, m_valid[0]);
    chk("a.s2s3", {s2_a, s3_a}, exp_filter(cur_off));
    chk("a.s0s1", {s0_a, s1_a}, 2);
    chk("b.color", color_b, m_color[1]);
    chk("b.color_valid", valid_b, m_valid[1]);
    chk("b.s2s3", {s2_b, s3_b}, exp_filter(cur_off));
    chk("b.s0s1", {s0_b, s1_b}, 2);
  end

  // Sensor stimulus: square wave whose period depends on the selected filter.
  // per_arr index 3 applies while idle or deciding; a period below 2 is silent.
  int per_arr [4] = '{0, 0, 0, 0};
  int ph = 0;
  initial begin
    int ch, per;
    sensor_out = 1'b0;
    forever begin
      @(negedge clk_1MHz);
      ph++;
      ch  = (cur_off < 0) ? 3 : cur_off / SW;
      per = per_arr[ch];
      sensor_out = (per >= 2) && ((ph % per) < (per / 2));
    end
  end

  task automatic set_per(input int r, input int g, input int b);
    per_arr[0] = r;
    per_arr[1] = g;
    per_arr[2] = b;
  endtask

  task automatic run_decides(input int n);
    int target, cyc;
    target = nd + n;
    cyc = 0;
    while (nd < target && cyc < n * P + 2000) begin
      @(negedge clk_1MHz);
      cyc++;
    end
    chk("decide_reached", (nd >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_off(input int o);
    int cyc;
    cyc = 0;
    while (cur_off != o && cyc < 2 * P) begin
      @(negedge clk_1MHz);
      cyc++;
    end
    chk("phase_reached", cur_off, o);
  endtask

  initial begin
    int reps;
    reset  = 1'b1;
    enable = 1'b0;
    model_reset();
    per_arr[3] = 3;

    // Reset held with the sensor toggling.
    repeat (20) @(negedge clk_1MHz);
    chk("rst.color", color_a, 0);
    chk("rst.valid", valid_a, 0);
    chk("rst.s2s3", {s2_a, s3_a}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_1MHz);

    // Red dominant for two cycles.
    set_per(4, 10, 10);
    enable = 1'b1;
    run_decides(2);
    chk("red.a", color_a, 1);
    chk("red.b", color_b, 1);

    // Green once, blue once: no update. Blue again: update.
    set_per(10, 4, 10);
    run_decides(1);
    chk("green_once", color_a, 1);
    set_per(10, 10, 4);
    run_decides(1);
    chk("blue_once", color_a, 1);
    run_decides(1);
    chk("blue_twice", color_a, 3);

    // Everything below MIN_COUNT.
    set_per(20, 20, 20);
    run_decides(2);
    chk("none.a", color_a, 0);
    chk("none.b", color_b, 0);

    // Three-way tie resolves to red.
    set_per(4, 4, 4);
    run_decides(2);
    chk("tie.a", color_a, 1);
    chk("tie.b", color_b, 1);

    // Enable dropped mid green window.
    wait_off(SW + S + 50);
    enable = 1'b0;
    @(negedge clk_1MHz);
    chk("drop.s2s3", {s2_a, s3_a}, 0);
    chk("drop.color", color_a, 1);
    repeat (30) @(negedge clk_1MHz);
    chk("idle.color", color_a, 1);
    set_per(4, 10, 10);
    enable = 1'b1;
    repeat (2) @(negedge clk_1MHz);
    chk("restart.s2s3", {s2_a, s3_a}, 0);
    run_decides(2);
    chk("restart.color", color_a, 1);

    // Saturation separates the two widths: 25 red vs 50 green.
    set_per(4, 2, 30);
    run_decides(2);
    chk("sat.a", color_a, 2);
    chk("sat.b", color_b, 1);

    // Reset in the middle of a red window.
    wait_off(S + 40);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst.color", color_a, 0);
    chk("midrst.valid", valid_a, 0);
    chk("midrst.s2s3", {s2_a, s3_a}, 0);
    repeat (3) @(negedge clk_1MHz);
    reset = 1'b0;

    // Randomised periods, with occasional enable dropouts.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        per_arr[0] = $urandom_range(2, 40);
        per_arr[1] = per_arr[0];
        per_arr[2] = per_arr[0];
      end else begin
        for (int c = 0; c < 3; c++)
          per_arr[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 40);
      end
      reps = $urandom_range(1, 3);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 300)) @(negedge clk_1MHz);
        enable = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk_1MHz);
        enable = 1'b1;
      end
      run_decides(reps);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
